wb_gpio_irq: RTL and testbench

//  Parametrised Wishbone B3 classic GPIO slave with per-bit direction and atomic set/clear.

---
 rtl/wb_gpio_irq.sv | 163 ++++++++++++++++
 tb/tb_wb_gpio_irq.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_gpio_irq.sv
// Wishbone B3 classic GPIO slave: per-bit direction, atomic set/clear, and synchronised
// edge-triggered sticky interrupt status combined into one level interrupt.
module wb_gpio_irq #(
    parameter int                    GPIO_WIDTH  = 32,
    parameter int                    SYNC_STAGES = 2,
    parameter logic [GPIO_WIDTH-1:0] RESET_OUT   = {GPIO_WIDTH{1'b0}},
    parameter logic [GPIO_WIDTH-1:0] RESET_DIR   = {GPIO_WIDTH{1'b0}}
) (
    input  logic                  wb_clk,
    input  logic                  wb_rst,
    input  logic [2:0]            wb_adr_i,
    input  logic [31:0]           wb_dat_i,
    input  logic                  wb_we_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic [3:0]            wb_sel_i,
    output logic [31:0]           wb_dat_o,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    output logic                  wb_rty_o,
    input  logic [GPIO_WIDTH-1:0] gpio_i,
    output logic [GPIO_WIDTH-1:0] gpio_o,
    output logic [GPIO_WIDTH-1:0] gpio_dir_o,
    output logic                  irq_o
);

    localparam logic [2:0] ADR_DATA_OUT = 3'd0;
    localparam logic [2:0] ADR_DIR      = 3'd1;
    localparam logic [2:0] ADR_DATA_IN  = 3'd2;
    localparam logic [2:0] ADR_OUT_SET  = 3'd3;
    localparam logic [2:0] ADR_OUT_CLR  = 3'd4;
    localparam logic [2:0] ADR_IRQ_EN   = 3'd5;
    localparam logic [2:0] ADR_IRQ_POL  = 3'd6;
    localparam logic [2:0] ADR_IRQ_STAT = 3'd7;

    logic [GPIO_WIDTH-1:0] out_r;
    logic [GPIO_WIDTH-1:0] dir_r;
    logic [GPIO_WIDTH-1:0] en_r;
    logic [GPIO_WIDTH-1:0] pol_r;
    logic [GPIO_WIDTH-1:0] stat_r;
    logic [GPIO_WIDTH-1:0] prev_r;
    logic [GPIO_WIDTH-1:0] sync_r [SYNC_STAGES];
    logic [31:0]           dat_r;
    logic                  ack_r;

    logic                  access_s;
    logic                  wr_s;
    logic                  rd_s;
    logic [31:0]           byte_mask_s;
    logic [GPIO_WIDTH-1:0] mask_s;
    logic [GPIO_WIDTH-1:0] wr_bits_s;
    logic [GPIO_WIDTH-1:0] sync_in_s;
    logic [GPIO_WIDTH-1:0] ev_s;
    logic [GPIO_WIDTH-1:0] data_in_s;
    logic [31:0]           rd_data_s;

    // The registered ack masks the second cycle of a held strobe, so each transfer commits once.
    assign access_s    = wb_cyc_i & wb_stb_i & ~ack_r;
    assign wr_s        = access_s & wb_we_i;
    assign rd_s        = access_s & ~wb_we_i;
    assign byte_mask_s = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
    assign mask_s      = byte_mask_s[GPIO_WIDTH-1:0];
    assign wr_bits_s   = wb_dat_i[GPIO_WIDTH-1:0] & mask_s;

    assign sync_in_s = sync_r[SYNC_STAGES-1];
    assign ev_s      = (pol_r & sync_in_s & ~prev_r) | (~pol_r & ~sync_in_s & prev_r);
    assign data_in_s = (sync_in_s & ~dir_r) | (out_r & dir_r);

    assign wb_dat_o   = dat_r;
    assign wb_ack_o   = ack_r;
    assign wb_err_o   = 1'b0;
    assign wb_rty_o   = 1'b0;
    assign gpio_o     = out_r;
    assign gpio_dir_o = dir_r;
    assign irq_o      = |(stat_r & en_r);

    // Input synchroniser chain and edge-history flop.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= {GPIO_WIDTH{1'b0}};
            end
            prev_r <= {GPIO_WIDTH{1'b0}};
        end else begin
            sync_r[0] <= gpio_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
            prev_r <= sync_in_s;
        end
    end

    // Writable control registers, byte-masked.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            out_r <= RESET_OUT;
            dir_r <= RESET_DIR;
            en_r  <= {GPIO_WIDTH{1'b0}};
            pol_r <= {GPIO_WIDTH{1'b0}};
        end else if (wr_s) begin
            case (wb_adr_i)
                ADR_DATA_OUT: out_r <= (out_r & ~mask_s) | wr_bits_s;
                ADR_DIR:      dir_r <= (dir_r & ~mask_s) | wr_bits_s;
                ADR_OUT_SET:  out_r <= out_r | wr_bits_s;
                ADR_OUT_CLR:  out_r <= out_r & ~wr_bits_s;
                ADR_IRQ_EN:   en_r  <= (en_r & ~mask_s) | wr_bits_s;
                ADR_IRQ_POL:  pol_r <= (pol_r & ~mask_s) | wr_bits_s;
                default: begin
                    out_r <= out_r;
                    dir_r <= dir_r;
                    en_r  <= en_r;
                    pol_r <= pol_r;
                end
            endcase
        end else begin
            out_r <= out_r;
            dir_r <= dir_r;
            en_r  <= en_r;
            pol_r <= pol_r;
        end
    end

    // Sticky status: new events are OR-ed after the clear, so a same-cycle edge survives W1C.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            stat_r <= {GPIO_WIDTH{1'b0}};
        end else if (wr_s && (wb_adr_i == ADR_IRQ_STAT)) begin
            stat_r <= (stat_r & ~wr_bits_s) | ev_s;
        end else begin
            stat_r <= stat_r | ev_s;
        end
    end

    // Read mux; bits above GPIO_WIDTH and write-only registers read as zero.
    always_comb begin
        rd_data_s = 32'd0;
        case (wb_adr_i)
            ADR_DATA_OUT: rd_data_s[GPIO_WIDTH-1:0] = out_r;
            ADR_DIR:      rd_data_s[GPIO_WIDTH-1:0] = dir_r;
            ADR_DATA_IN:  rd_data_s[GPIO_WIDTH-1:0] = data_in_s;
            ADR_IRQ_EN:   rd_data_s[GPIO_WIDTH-1:0] = en_r;
            ADR_IRQ_POL:  rd_data_s[GPIO_WIDTH-1:0] = pol_r;
            ADR_IRQ_STAT: rd_data_s[GPIO_WIDTH-1:0] = stat_r;
            default:      rd_data_s = 32'd0;
        endcase
    end

    // Bus response: one-cycle ack, read data captured on the access cycle.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            ack_r <= 1'b0;
            dat_r <= 32'd0;
        end else begin
            ack_r <= access_s;
            if (rd_s) begin
                dat_r <= rd_data_s;
            end else begin
                dat_r <= dat_r;
            end
        end
    end

endmodule

// File: tb/tb_wb_gpio_irq.sv
// Scoreboard bench for wb_gpio_irq: a 32-bit instance for the main function and an
// 8-bit instance for the narrow-width masking.
module tb_wb_gpio_irq;

    localparam int SYNC = 2;

    logic        wb_clk = 1'b0;
    logic        wb_rst;
    logic [2:0]  adr;
    logic [31:0] dat_i;
    logic        we, cyc, cyc8, stb;
    logic [3:0]  sel;
    logic [31:0] dat_o, dat8_o;
    logic        ack, ack8, err, rty, err8, rty8;
    logic [31:0] gpio_i, gpio_o, dir_o;
    logic [7:0]  gpio8_i, gpio8_o, dir8_o;
    logic        irq, irq8;

    int          n_cmp = 0;
    int          n_bad = 0;
    string       tag_q[$];
    logic [31:0] exp_q[$];

    always #5 wb_clk = ~wb_clk;

    wb_gpio_irq #(.GPIO_WIDTH(32), .SYNC_STAGES(SYNC)) u_dut (
        .wb_clk(wb_clk), .wb_rst(wb_rst), .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_we_i(we),
        .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_sel_i(sel), .wb_dat_o(dat_o), .wb_ack_o(ack),
        .wb_err_o(err), .wb_rty_o(rty), .gpio_i(gpio_i), .gpio_o(gpio_o),
        .gpio_dir_o(dir_o), .irq_o(irq)
    );

    wb_gpio_irq #(.GPIO_WIDTH(8), .SYNC_STAGES(SYNC)) u_dut8 (
        .wb_clk(wb_clk), .wb_rst(wb_rst), .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_we_i(we),
        .wb_cyc_i(cyc8), .wb_stb_i(stb), .wb_sel_i(sel), .wb_dat_o(dat8_o), .wb_ack_o(ack8),
        .wb_err_o(err8), .wb_rty_o(rty8), .gpio_i(gpio8_i), .gpio_o(gpio8_o),
        .gpio_dir_o(dir8_o), .irq_o(irq8)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Read responses are popped from the scoreboard whenever either slave acks a read.
    always @(negedge wb_clk) begin
        if (!wb_rst && (ack || ack8) && !we) begin
            check_eq("err_rty", {28'd0, err, rty, err8, rty8}, 32'd0);
            if (exp_q.size() == 0) begin
                check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
                check_eq(tag_q.pop_front(), ack8 ? dat8_o : dat_o, exp_q.pop_front());
            end
        end
    end

    task automatic bus_xfer(input bit tgt8, input logic [2:0] a, input logic we_v,
                            input logic [31:0] d, input logic [3:0] s,
                            input string tag, input logic [31:0] exp);
        bit seen;
        if (!we_v) begin
            tag_q.push_back(tag);
            exp_q.push_back(exp);
        end
        @(negedge wb_clk);
        cyc = !tgt8; cyc8 = tgt8; stb = 1'b1; we = we_v; adr = a; dat_i = d; sel = s;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge wb_clk);
            if (tgt8 ? ack8 : ack) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq({tag, "_ack"}, 32'(seen), 32'd1);
        if (!seen && !we_v) begin
            void'(tag_q.pop_back());
            void'(exp_q.pop_back());
        end
        cyc = 1'b0; cyc8 = 1'b0; stb = 1'b0;
        @(negedge wb_clk);
        check_eq({tag, "_ack_1cyc"}, 32'(tgt8 ? ack8 : ack), 32'd0);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
        bus_xfer(1'b0, a, 1'b1, d, s, "wr", 32'd0);
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
        bus_xfer(1'b0, a, 1'b0, 32'd0, 4'hF, tag, exp);
    endtask

    initial begin
        bit seen;
        wb_rst = 1'b1; adr = 3'd0; dat_i = 32'd0; we = 1'b0; cyc = 1'b0; cyc8 = 1'b0;
        stb = 1'b0; sel = 4'h0; gpio_i = 32'd0; gpio8_i = 8'd0;
        repeat (3) @(negedge wb_clk);
        wb_rst = 1'b0;

        // Reset state.
        check_eq("rst_irq", 32'(irq), 32'd0);
        check_eq("rst_gpio_o", gpio_o, 32'd0);
        check_eq("rst_dir", dir_o, 32'd0);
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), 32'd0, $sformatf("rst_reg%0d", a));
        end

        // Reset mid-transfer: ack drops at once, held transfer is acked again afterwards.
        @(negedge wb_clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 3'd0; dat_i = 32'h55; sel = 4'hF;
        @(negedge wb_clk);
        check_eq("pre_rst_ack", 32'(ack), 32'd1);
        wb_rst = 1'b1;
        #1;
        check_eq("mid_rst_ack", 32'(ack), 32'd0);
        check_eq("mid_rst_gpio", gpio_o, 32'd0);
        @(negedge wb_clk);
        wb_rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge wb_clk);
            if (ack) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("reack", 32'(seen), 32'd1);
        cyc = 1'b0; stb = 1'b0;
        check_eq("reack_gpio", gpio_o, 32'h55);
        @(negedge wb_clk);

        // Byte-masked write, atomic set and clear.
        wr(3'd0, 32'h0000_00FF, 4'b0001);
        check_eq("wr_lane0", gpio_o, 32'h0000_00FF);
        wr(3'd3, 32'h0000_0100, 4'hF);
        check_eq("out_set", gpio_o, 32'h0000_01FF);
        wr(3'd4, 32'h0000_000F, 4'hF);
        check_eq("out_clr", gpio_o, 32'h0000_01F0);
        wr(3'd0, 32'hFFFF_FFFF, 4'b0100);
        rd(3'd0, 32'h00FF_01F0, "rd_lane2");
        rd(3'd3, 32'd0, "rd_out_set");

        // Mixed-direction readback.
        wr(3'd1, 32'hFFFF_0000, 4'hF);
        wr(3'd0, 32'hAAAA_AAAA, 4'hF);
        gpio_i = 32'h1234_5678;
        repeat (SYNC + 2) @(negedge wb_clk);
        rd(3'd2, 32'hAAAA_5678, "data_in");
        wr(3'd2, 32'h0, 4'hF);
        check_eq("data_in_ro", gpio_o, 32'hAAAA_AAAA);

        // Falling edges with POL=0 latch while masked; partial and full W1C.
        gpio_i = 32'd0;
        repeat (SYNC + 2) @(negedge wb_clk);
        check_eq("masked_irq", 32'(irq), 32'd0);
        rd(3'd7, 32'h1234_5678, "stat_fall");
        wr(3'd7, 32'h0000_0078, 4'hF);
        rd(3'd7, 32'h1234_5600, "stat_w1c_part");
        wr(3'd7, 32'hFFFF_FFFF, 4'hF);
        rd(3'd7, 32'd0, "stat_w1c_all");

        // Rising edge on bit 3 with exact latency.
        wr(3'd5, 32'h8, 4'hF);
        wr(3'd6, 32'h8, 4'hF);
        @(negedge wb_clk);
        gpio_i[3] = 1'b1;
        for (int k = 1; k <= SYNC + 1; k++) begin
            @(negedge wb_clk);
            check_eq($sformatf("lat_irq_%0d", k), 32'(irq), (k == SYNC + 1) ? 32'd1 : 32'd0);
        end
        rd(3'd7, 32'h8, "stat_rise");
        wr(3'd7, 32'h8, 4'hF);
        check_eq("irq_cleared", 32'(irq), 32'd0);

        // Falling edge with POL=1: no event.
        gpio_i[3] = 1'b0;
        repeat (SYNC + 3) @(negedge wb_clk);
        rd(3'd7, 32'd0, "stat_fall_ign");
        check_eq("irq_fall_ign", 32'(irq), 32'd0);

        // Re-arm, then W1C in the same cycle a new rising edge is detected.
        gpio_i[3] = 1'b1;
        repeat (SYNC + 3) @(negedge wb_clk);
        check_eq("irq_rearm", 32'(irq), 32'd1);
        gpio_i[3] = 1'b0;
        repeat (SYNC + 3) @(negedge wb_clk);
        gpio_i[3] = 1'b1;
        repeat (SYNC - 1) @(negedge wb_clk);
        wr(3'd7, 32'h8, 4'hF);
        check_eq("w1c_race_irq", 32'(irq), 32'd1);
        rd(3'd7, 32'h8, "w1c_race_stat");

        // Polarity change with a steady input creates no event.
        wr(3'd7, 32'h8, 4'hF);
        wr(3'd6, 32'h0, 4'hF);
        repeat (SYNC + 2) @(negedge wb_clk);
        rd(3'd7, 32'd0, "pol_change");
        check_eq("pol_change_irq", 32'(irq), 32'd0);

        // Narrow instance: bits above GPIO_WIDTH are dropped.
        bus_xfer(1'b1, 3'd0, 1'b1, 32'hFFFF_FFFF, 4'hF, "wr8", 32'd0);
        check_eq("gpio8_o", 32'(gpio8_o), 32'h0000_00FF);
        bus_xfer(1'b1, 3'd0, 1'b0, 32'd0, 4'hF, "rd8_data_out", 32'h0000_00FF);
        bus_xfer(1'b1, 3'd1, 1'b0, 32'd0, 4'hF, "rd8_dir", 32'd0);

        check_eq("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
